// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM states, funct3 access
// sizes, and the lane-mask / read-modify-write merge helpers.
package data_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_MERGE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   // Halfwords are placed on an even lane pair, so only byte_off[1] matters.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] byte_off);
      logic [3:0] mask;
      case (size)
         SZ_BYTE: mask = 4'b0001 << byte_off;
         SZ_HALF: mask = 4'b0011 << {byte_off[1], 1'b0};
         SZ_WORD: mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

   function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the bit-serial data serialiser (master) and the
// data-memory controller (slave). Suffixes are from the controller's viewpoint.
interface data_mem_ctrl_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              req_i;
   logic              we_i;
   logic [ADDR_W-1:0] addr_i;
   logic [1:0]        byte_off_i;
   logic [2:0]        func_i;
   logic              misaligned_i;
   logic [31:0]       wdata_i;
   logic [31:0]       rdata_o;
   logic              busy_o;
   logic              done_o;
   logic              fault_o;

   modport master (
      output req_i, we_i, addr_i, byte_off_i, func_i, misaligned_i, wdata_i,
      input  rdata_o, busy_o, done_o, fault_o
   );

   modport slave (
      input  req_i, we_i, addr_i, byte_off_i, func_i, misaligned_i, wdata_i,
      output rdata_o, busy_o, done_o, fault_o
   );
endinterface

// File: rtl/data_mem_ctrl_data_ram.sv
// Single-port data RAM: synchronous read, full-word write, no byte enables and
// no reset of its contents.
module data_mem_ctrl_data_ram #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned DEPTH     = 1024,
   parameter string       INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // Write-first is irrelevant here: the controller never reads back in the write cycle.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one load/store at a time, sub-word stores done as a
// read-modify-write on a RAM without byte enables.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned DEPTH     = 1024,
   parameter string       INIT_FILE = ""
) (
   input logic             clk,
   input logic             rst,
   data_mem_ctrl_if.slave  bus
);

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [3:0]        mask_q;
   logic [31:0]       rdata_q;
   logic              busy_q;
   logic              done_q;
   logic              fault_q;

   logic              req_bad_s;
   logic              ram_we_s;
   logic [31:0]       ram_rdata_s;
   logic [31:0]       ram_wdata_s;
   logic              unused_s;

   // Requests that would touch the RAM illegally are aborted without access.
   always_comb begin
      req_bad_s = bus.misaligned_i | (bus.func_i[1:0] == SZ_ILL);
   end

   // Reset in MERGE must suppress the write, hence the combinational rst term.
   always_comb begin
      ram_we_s    = (state_q == ST_MERGE) & we_q & ~rst;
      ram_wdata_s = merge_word(ram_rdata_s, wdata_q, mask_q);
   end

   // funct3[2] selects sign handling, which is done in the serialiser.
   assign unused_s = bus.func_i[2];

   data_mem_ctrl_data_ram #(
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we_s),
      .addr_i  (addr_q),
      .wdata_i (ram_wdata_s),
      .rdata_o (ram_rdata_s)
   );

   // Transaction FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= 32'h0000_0000;
         mask_q  <= 4'b0000;
         rdata_q <= 32'h0000_0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.req_i) begin
                  addr_q  <= bus.addr_i;
                  we_q    <= bus.we_i;
                  wdata_q <= bus.wdata_i;
                  mask_q  <= lane_mask(bus.func_i[1:0], bus.byte_off_i);
                  busy_q  <= 1'b1;
                  if (req_bad_s) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     fault_q <= 1'b1;
                  end else begin
                     state_q <= ST_READ;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_READ: begin
               state_q <= ST_MERGE;
            end
            ST_MERGE: begin
               if (!we_q) begin
                  rdata_q <= ram_rdata_s;
               end
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rdata_o = rdata_q;
   assign bus.busy_o  = busy_q;
   assign bus.done_o  = done_q;
   assign bus.fault_o = fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vector table, hand-written
// reset/busy corner cases, then random traffic against a word-array model.
module tb_data_mem_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   data_mem_ctrl_if #(.ADDR_W(10)) bus ();

   data_mem_ctrl #(
      .ADDR_W    (10),
      .DEPTH     (1024),
      .INIT_FILE ("")
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        we;
      logic [9:0]  addr;
      logic [1:0]  off;
      logic [2:0]  func;
      logic        mis;
      logic [31:0] wdata;
      int          exp_lat;
      logic        exp_fault;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        vecs [18];
   logic [31:0] mem_m [16];
   logic [31:0] rdata_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: sizes in bytes and starting lane, straight from funct3 rules.
   task automatic model(input logic we, input logic [9:0] a, input logic [1:0] off,
                        input logic [2:0] f, input logic mis, input logic [31:0] wd,
                        output int lat, output logic flt);
      int nb;
      int st;
      if (mis || f[1:0] == 2'b11) begin
         lat = 1;
         flt = 1'b1;
      end else begin
         lat = 3;
         flt = 1'b0;
         if (we) begin
            case (f[1:0])
               2'b00:   begin nb = 1; st = int'(off);        end
               2'b01:   begin nb = 2; st = off[1] ? 2 : 0;   end
               default: begin nb = 4; st = 0;                end
            endcase
            for (int k = st; k < st + nb; k++) begin
               mem_m[a[3:0]][8*k +: 8] = wd[8*k +: 8];
            end
         end else begin
            rdata_m = mem_m[a[3:0]];
         end
      end
   endtask

   task automatic drive(input logic we, input logic [9:0] a, input logic [1:0] off,
                        input logic [2:0] f, input logic mis, input logic [31:0] wd,
                        output int lat, output logic flt, output logic busy1);
      @(negedge clk);
      bus.req_i        = 1'b1;
      bus.we_i         = we;
      bus.addr_i       = a;
      bus.byte_off_i   = off;
      bus.func_i       = f;
      bus.misaligned_i = mis;
      bus.wdata_i      = wd;
      @(negedge clk);
      bus.req_i = 1'b0;
      lat       = 1;
      busy1     = bus.busy_o;
      while (bus.done_o !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      flt = bus.fault_o;
      if (bus.done_o !== 1'b1) begin
         lat = -1;
      end
   endtask

   task automatic txn(input string name, input logic we, input logic [9:0] a,
                      input logic [1:0] off, input logic [2:0] f, input logic mis,
                      input logic [31:0] wd);
      int   lat;
      int   exp_lat;
      logic flt;
      logic exp_flt;
      logic b1;
      model(we, a, off, f, mis, wd, exp_lat, exp_flt);
      drive(we, a, off, f, mis, wd, lat, flt, b1);
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
      chk({name, " fault"}, {31'd0, flt}, {31'd0, exp_flt});
      chk({name, " rdata"}, bus.rdata_o, rdata_m);
   endtask

   initial begin
      int   lat;
      int   dones;
      logic flt;
      logic b1;
      logic [31:0] wd;

      vecs[0]  = '{1'b1, 10'd5, 2'd0, 3'b010, 1'b0, 32'hDEADBEEF, 3, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b0, 10'd5, 2'd0, 3'b010, 1'b0, 32'h0000_0000, 3, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 10'd3, 2'd0, 3'b010, 1'b0, 32'h11223344, 3, 1'b0, 32'hDEADBEEF};
      vecs[3]  = '{1'b1, 10'd3, 2'd2, 3'b000, 1'b0, 32'h00AA0000, 3, 1'b0, 32'hDEADBEEF};
      vecs[4]  = '{1'b0, 10'd3, 2'd0, 3'b010, 1'b0, 32'h0000_0000, 3, 1'b0, 32'h11AA3344};
      vecs[5]  = '{1'b1, 10'd3, 2'd0, 3'b010, 1'b0, 32'h11223344, 3, 1'b0, 32'h11AA3344};
      vecs[6]  = '{1'b1, 10'd3, 2'd2, 3'b001, 1'b0, 32'hBEEF0000, 3, 1'b0, 32'h11AA3344};
      vecs[7]  = '{1'b0, 10'd3, 2'd0, 3'b010, 1'b0, 32'h0000_0000, 3, 1'b0, 32'hBEEF3344};
      vecs[8]  = '{1'b1, 10'd7, 2'd0, 3'b010, 1'b0, 32'hCAFEF00D, 3, 1'b0, 32'hBEEF3344};
      vecs[9]  = '{1'b0, 10'd7, 2'd0, 3'b010, 1'b0, 32'h0000_0000, 3, 1'b0, 32'hCAFEF00D};
      vecs[10] = '{1'b1, 10'd7, 2'd0, 3'b010, 1'b1, 32'h12345678, 1, 1'b1, 32'hCAFEF00D};
      vecs[11] = '{1'b1, 10'd7, 2'd0, 3'b011, 1'b0, 32'h12345678, 1, 1'b1, 32'hCAFEF00D};
      vecs[12] = '{1'b0, 10'd7, 2'd0, 3'b010, 1'b0, 32'h0000_0000, 3, 1'b0, 32'hCAFEF00D};
      vecs[13] = '{1'b0, 10'd5, 2'd0, 3'b010, 1'b1, 32'h0000_0000, 1, 1'b1, 32'hCAFEF00D};
      vecs[14] = '{1'b1, 10'd5, 2'd1, 3'b100, 1'b0, 32'h00001100, 3, 1'b0, 32'hCAFEF00D};
      vecs[15] = '{1'b0, 10'd5, 2'd0, 3'b110, 1'b0, 32'h0000_0000, 3, 1'b0, 32'hDEAD11EF};
      vecs[16] = '{1'b1, 10'd5, 2'd0, 3'b101, 1'b0, 32'h0000ABCD, 3, 1'b0, 32'hDEAD11EF};
      vecs[17] = '{1'b0, 10'd5, 2'd0, 3'b010, 1'b0, 32'h0000_0000, 3, 1'b0, 32'hDEADABCD};

      rst              = 1'b1;
      bus.req_i        = 1'b0;
      bus.we_i         = 1'b0;
      bus.addr_i       = 10'd0;
      bus.byte_off_i   = 2'd0;
      bus.func_i       = 3'b010;
      bus.misaligned_i = 1'b0;
      bus.wdata_i      = 32'h0000_0000;
      rdata_m          = 32'h0000_0000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset rdata", bus.rdata_o, 32'h0000_0000);
      chk("reset busy", {31'd0, bus.busy_o}, 32'd0);
      chk("reset done", {31'd0, bus.done_o}, 32'd0);
      chk("reset fault", {31'd0, bus.fault_o}, 32'd0);

      for (int i = 0; i < 18; i++) begin
         int   ml;
         logic mf;
         model(vecs[i].we, vecs[i].addr, vecs[i].off, vecs[i].func, vecs[i].mis, vecs[i].wdata, ml, mf);
         drive(vecs[i].we, vecs[i].addr, vecs[i].off, vecs[i].func, vecs[i].mis, vecs[i].wdata, lat, flt, b1);
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("vec%0d fault", i), {31'd0, flt}, {31'd0, vecs[i].exp_fault});
         chk($sformatf("vec%0d rdata", i), bus.rdata_o, vecs[i].exp_rdata);
         chk($sformatf("vec%0d busy", i), {31'd0, b1}, 32'd1);
      end
      @(negedge clk);
      chk("busy after done", {31'd0, bus.busy_o}, 32'd0);

      for (int a = 0; a < 16; a++) begin
         txn("init", 1'b1, 10'(a), 2'd0, 3'b010, 1'b0, $urandom);
      end

      // Reset while a byte store sits in MERGE.
      wd = ~mem_m[9];
      dones = 0;
      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 10'd9; bus.byte_off_i = 2'd0;
      bus.func_i = 3'b000; bus.misaligned_i = 1'b0; bus.wdata_i = wd;
      @(negedge clk);
      bus.req_i = 1'b0;
      dones += int'(bus.done_o);
      @(negedge clk);
      rst = 1'b1;
      dones += int'(bus.done_o);
      @(negedge clk);
      rst = 1'b0;
      dones += int'(bus.done_o);
      chk("rst-merge busy", {31'd0, bus.busy_o}, 32'd0);
      rdata_m = 32'h0000_0000;
      chk("rst-merge rdata", bus.rdata_o, rdata_m);
      @(negedge clk);
      dones += int'(bus.done_o);
      chk("rst-merge done count", 32'(dones), 32'd0);
      txn("rst-merge ram", 1'b0, 10'd9, 2'd0, 3'b010, 1'b0, 32'h0);

      // Reset and req together: request dropped.
      @(negedge clk);
      rst = 1'b1;
      bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 10'd9; bus.func_i = 3'b010;
      bus.wdata_i = ~mem_m[9];
      @(negedge clk);
      rst = 1'b0;
      bus.req_i = 1'b0;
      rdata_m = 32'h0000_0000;
      @(negedge clk);
      chk("rst-req busy", {31'd0, bus.busy_o}, 32'd0);
      chk("rst-req done", {31'd0, bus.done_o}, 32'd0);
      txn("rst-req ram", 1'b0, 10'd9, 2'd0, 3'b010, 1'b0, 32'h0);

      // Second request held during READ and MERGE must be ignored.
      model(1'b1, 10'd11, 2'd0, 3'b010, 1'b0, 32'h0BADF00D, lat, flt);
      dones = 0;
      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 10'd11; bus.byte_off_i = 2'd0;
      bus.func_i = 3'b010; bus.misaligned_i = 1'b0; bus.wdata_i = 32'h0BADF00D;
      @(negedge clk);
      bus.wdata_i = 32'hFFFF_FFFF;
      dones += int'(bus.done_o);
      @(negedge clk);
      dones += int'(bus.done_o);
      @(negedge clk);
      bus.req_i = 1'b0;
      dones += int'(bus.done_o);
      repeat (5) begin
         @(negedge clk);
         dones += int'(bus.done_o);
      end
      chk("busy-ignore done count", 32'(dones), 32'd1);
      txn("busy-ignore ram", 1'b0, 10'd11, 2'd0, 3'b010, 1'b0, 32'h0);

      for (int i = 0; i < 300; i++) begin
         txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
             2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 7) == 0), $urandom);
      end

      for (int a = 0; a < 16; a++) begin
         txn($sformatf("final%0d", a), 1'b0, 10'(a), 2'd0, 3'b010, 1'b0, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
